hram_arbiter: RTL and testbench
===============================

// Module: hram_arbiter
// PURPOSE
//  Two-port round-robin arbiter sharing one hram controller (valid/ready/wstrb memory bus) between
//  CPU (port 0) and video/DMA (port 1). Holds the downstream bus for one owner per transaction,
//  forwards ready/rdata only to that owner and inserts a release cycle between transactions.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  downstream wait limit in BUSY, cycles; used only with HRAM_ARB_TIMEOUT_EN
//  TO_W            11    timeout counter width; must satisfy 2**TO_W > TIMEOUT_CYCLES
// PORTS
//  clk        in   1   system clock, single clock domain
//  rst        in   1   synchronous reset, active-high
//  m0_valid   in   1   port 0 request; held until m0_ready
//  m0_addr    in   32  port 0 byte address
//  m0_wdata   in   32  port 0 write data
//  m0_wstrb   in   4   port 0 byte strobes; 0 = read
//  m0_rdata   out  32  port 0 read data, valid while m0_ready=1
//  m0_ready   out  1   port 0 completion pulse
//  m1_*       -    -   identical set for port 1
//  s_valid    out  1   to hram valid
//  s_addr     out  32  to hram addr
//  s_wdata    out  32  to hram wdata
//  s_wstrb    out  4   to hram wstrb
//  s_rdata    in   32  from hram rdata
//  s_ready    in   1   from hram ready
//  timeout    out  1   sticky flag: a transaction was aborted by the watchdog
// BEHAVIOUR
//  - States: IDLE -> BUSY -> RELEASE -> IDLE. Registers: state, owner (1b), last (1b), tcnt.
//  - IDLE: when m0_valid|m1_valid, pick owner. Both valid -> owner = ~last. One valid -> that port.
//    Load owner and last<=picked. Go to BUSY on the next edge.
//  - BUSY: s_valid=1. s_addr/s_wdata/s_wstrb mux combinationally from owner's inputs.
//    When s_ready=1: mN_ready=1 for owner only (same cycle, combinational) and mN_rdata=s_rdata.
//    Then go to RELEASE.
//  - RELEASE: s_valid=0 for exactly one cycle. No grant is issued. Then IDLE.
//  - Latency: request seen in IDLE at edge t -> s_valid high after edge t+1. Minimum turnaround
//    between back-to-back grants is 2 cycles after ready.
//  - Non-owner ready is always 0. Non-owner rdata = 0. In IDLE/RELEASE, s_addr/s_wdata/s_wstrb = 0.
//  - Valid dropped by the owner while BUSY is a protocol error. The arbiter stays in BUSY until
//    s_ready; it never aborts on that.
//  - s_ready outside BUSY is ignored.
//  - Reset values: state=IDLE, owner=0, last=1 (port 0 wins the first contention), tcnt=0,
//    timeout=0, all outputs 0. Reset mid-BUSY returns to IDLE at once. hram shares rst and is
//    reset too.
//  - Simultaneous new request and ready: the new request waits. It is arbitrated in IDLE after RELEASE.
// CONFIGURATION
//  HRAM_ARB_TIMEOUT_EN defined:
//    - tcnt clears on BUSY entry and counts each BUSY cycle without s_ready.
//    - At tcnt==TIMEOUT_CYCLES-1 with no s_ready: owner gets mN_ready=1 and mN_rdata=32'hDEAD_BEEF,
//      s_valid drops, state -> RELEASE, timeout<=1 (sticky until rst).
//    - s_ready on that same cycle wins: normal completion, no timeout.
//  HRAM_ARB_TIMEOUT_EN undefined:
//    - No counter. BUSY waits indefinitely. timeout tied 0. TIMEOUT_CYCLES and TO_W unused.
// STRUCTURE
//  - hram_arb_pkg.vh: state encodings (ST_IDLE=0, ST_BUSY=1, ST_RELEASE=2), port ids,
//    HRAM_ARB_ABORT_DATA=32'hDEAD_BEEF.
//  - Sub-module hram_arb_rr: combinational 2-way round-robin pick (req[1:0], last -> grant).
//    Instantiated once.
// TESTING
//  1 Reset: rst=1 for 3 cycles with m0_valid=1 -> s_valid=0, m0_ready=0, timeout=0 throughout;
//    first grant goes to port 0.
//  2 Single write: m0 addr=0, wdata=32'h12345678, wstrb=4'b1010 -> s_* match after 1 cycle;
//    m0_ready pulses with s_ready; s_valid=0 for 1 cycle afterwards.
//  3 Contention: m0 and m1 valid together, 4 transactions each -> grants alternate 0,1,0,1...;
//    m1_ready never asserts during a port-0 grant.
//  4 Read routing: m1 read addr=2, s_rdata=32'hCAFEF00D -> m1_rdata=32'hCAFEF00D with m1_ready;
//    m0_rdata=0.
//  5 Reset mid-BUSY: assert rst while s_valid=1 -> next cycle IDLE, s_valid=0, no ready to owner.
//  6 (HRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16) s_ready held 0 -> after 16 BUSY cycles, m0_ready=1,
//    m0_rdata=32'hDEADBEEF, timeout=1 and stays 1.

Source files
------------

// File: rtl/hram_arb_pkg.sv
// Shared definitions for the two-port hram arbiter: FSM state encoding,
// port identifiers and the data word returned on a watchdog abort.
package hram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam logic [31:0] HRAM_ARB_ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/hram_arb_rr.sv
// Combinational 2-way round-robin pick. With both ports requesting, the
// port that did not win last time gets the grant; otherwise the lone
// requester wins. With no request the result is don't-care (port 0).
module hram_arb_rr
  import hram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  // Pick the next owner from the current requests and the previous winner.
  always_comb begin
    grant = PORT_CPU;
    if (req == 2'b11) begin
      grant = ~last;
    end else if (req[1]) begin
      grant = PORT_DMA;
    end
  end

endmodule

// File: rtl/hram_arbiter.sv
// Two-port round-robin arbiter in front of a single hram controller.
// Port 0 is the CPU, port 1 is video/DMA. One owner holds the downstream
// bus per transaction; ready/rdata are routed only to that owner and one
// idle release cycle separates consecutive transactions.
// Optional build macro HRAM_ARB_TIMEOUT_EN adds a BUSY watchdog that
// aborts the transaction with HRAM_ARB_ABORT_DATA and sets a sticky
// timeout flag.
module hram_arbiter
  import hram_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic        timeout
);

  state_t      state, state_nxt;
  logic        owner, owner_nxt;
  logic        last, last_nxt;
  logic        grant;
  logic        abort;
  logic [31:0] done_data;

  hram_arb_rr u_rr (
    .req   ({m1_valid, m0_valid}),
    .last  (last),
    .grant (grant)
  );

  // A real completion always beats a watchdog abort on the same cycle.
  assign done_data = s_ready ? s_rdata : HRAM_ARB_ABORT_DATA;

`ifdef HRAM_ARB_TIMEOUT_EN
  logic [TO_W-1:0] tcnt;
  logic            timeout_q;

  assign abort = (state == ST_BUSY) && !s_ready &&
                 (tcnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: count BUSY cycles without ready; held at zero outside BUSY so
  // every transaction starts from a clean count.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state != ST_BUSY) begin
        tcnt <= '0;
      end else if (!s_ready) begin
        tcnt <= tcnt + 1'b1;
      end
      if (abort) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  logic unused_cfg;
  logic timeout_q;

  assign abort      = 1'b0;
  assign timeout_q  = 1'b0;
  assign unused_cfg = ^{TIMEOUT_CYCLES[0], TO_W[0]};
`endif

  // State register; last starts at port 1 so port 0 wins the first contention.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= PORT_CPU;
      last  <= PORT_DMA;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  // Next-state logic and the combinational bus/response routing.
  // NOTE: every output gets a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    s_valid   = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    timeout   = timeout_q;

    unique case (state)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          owner_nxt = grant;
          last_nxt  = grant;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        s_valid = 1'b1;
        if (owner == PORT_DMA) begin
          s_addr  = m1_addr;
          s_wdata = m1_wdata;
          s_wstrb = m1_wstrb;
        end else begin
          s_addr  = m0_addr;
          s_wdata = m0_wdata;
          s_wstrb = m0_wstrb;
        end
        if (s_ready || abort) begin
          if (owner == PORT_DMA) begin
            m1_ready = 1'b1;
            m1_rdata = done_data;
          end else begin
            m0_ready = 1'b1;
            m0_rdata = done_data;
          end
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // While reset is asserted nothing is granted or completed, even if the
    // registers still hold a BUSY state from before the reset.
    if (rst) begin
      s_valid  = 1'b0;
      s_addr   = '0;
      s_wdata  = '0;
      s_wstrb  = '0;
      m0_ready = 1'b0;
      m1_ready = 1'b0;
      m0_rdata = '0;
      m1_rdata = '0;
      timeout  = 1'b0;
    end
  end

endmodule

// File: tb/tb_hram_arbiter.sv
// Self-checking bench for hram_arbiter: a transaction-level model runs in
// parallel and is compared against the DUT every cycle, alongside directed
// scenarios with literal expectations.
module tb_hram_arbiter;

  localparam int TO_CYC = 16;
  localparam int TO_W   = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic        timeout;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  hram_arbiter #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(TO_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_valid (m0_valid),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_wstrb (m0_wstrb),
    .m0_rdata (m0_rdata),
    .m0_ready (m0_ready),
    .m1_valid (m1_valid),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_wstrb (m1_wstrb),
    .m1_rdata (m1_rdata),
    .m1_ready (m1_ready),
    .s_valid  (s_valid),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_rdata  (s_rdata),
    .s_ready  (s_ready),
    .timeout  (timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: is a grant in progress, who owns it, how long
  // it has waited, how many dead cycles remain before the next grant.
  bit mdl_busy = 1'b0;
  bit mdl_own  = 1'b0;
  bit mdl_last = 1'b1;
  int mdl_age  = 0;
  int mdl_cool = 0;
  bit mdl_to   = 1'b0;

  function automatic bit mdl_abort();
    bit ab;
    ab = 1'b0;
`ifdef HRAM_ARB_TIMEOUT_EN
    ab = mdl_busy && !s_ready && (mdl_age == TO_CYC - 1);
`endif
    return ab;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mdl_busy <= 1'b0;
      mdl_own  <= 1'b0;
      mdl_last <= 1'b1;
      mdl_age  <= 0;
      mdl_cool <= 0;
      mdl_to   <= 1'b0;
    end else if (mdl_busy) begin
      if (s_ready || mdl_abort()) begin
        if (!s_ready) mdl_to <= 1'b1;
        mdl_busy <= 1'b0;
        mdl_cool <= 1;
      end else begin
        mdl_age <= mdl_age + 1;
      end
    end else if (mdl_cool > 0) begin
      mdl_cool <= mdl_cool - 1;
    end else if (m0_valid || m1_valid) begin
      mdl_own  <= (m0_valid && m1_valid) ? !mdl_last : m1_valid;
      mdl_last <= (m0_valid && m1_valid) ? !mdl_last : m1_valid;
      mdl_busy <= 1'b1;
      mdl_age  <= 0;
    end
  end

  // Compare the DUT with the model on every falling edge.
  always @(negedge clk) begin
    bit          ev, ab, r0, r1;
    logic [31:0] rd;
    if (cmp_en) begin
      ab = mdl_abort() && !rst;
      ev = mdl_busy && !rst;
      r0 = ev && !mdl_own && (s_ready || ab);
      r1 = ev && mdl_own && (s_ready || ab);
      rd = s_ready ? s_rdata : 32'hDEAD_BEEF;
      check("cmp s_valid", s_valid, ev);
      check("cmp s_addr", s_addr, ev ? (mdl_own ? m1_addr : m0_addr) : 32'h0);
      check("cmp s_wdata", s_wdata, ev ? (mdl_own ? m1_wdata : m0_wdata) : 32'h0);
      check("cmp s_wstrb", s_wstrb, ev ? (mdl_own ? m1_wstrb : m0_wstrb) : 4'h0);
      check("cmp m0_ready", m0_ready, r0);
      check("cmp m1_ready", m1_ready, r1);
      if (r0) check("cmp m0_rdata", m0_rdata, rd);
      if (r1) check("cmp m1_rdata", m1_rdata, rd);
      if (ev && mdl_own) check("cmp m0_rdata nonowner", m0_rdata, 32'h0);
      if (ev && !mdl_own) check("cmp m1_rdata nonowner", m1_rdata, 32'h0);
      check("cmp timeout", timeout, mdl_to && !rst);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_svalid(input int max, input string name);
    int n;
    n = 0;
    while (!s_valid && n < max) begin
      tick();
      n++;
    end
    check(name, s_valid, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    bit g;
    int cnt0, cnt1, n;
    rst = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'h0; m0_wdata = 32'h1234_5678; m0_wstrb = 4'b1010;
    m1_valid = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    s_ready = 1'b0; s_rdata = 32'h0;
    cmp_en = 1'b1;

    // Reset held three cycles with a pending port-0 request.
    repeat (3) begin
      tick();
      check("rst s_valid", s_valid, 1'b0);
      check("rst m0_ready", m0_ready, 1'b0);
      check("rst timeout", timeout, 1'b0);
    end
    rst = 1'b0;

    // Single write from port 0.
    tick();
    check("wr s_valid", s_valid, 1'b1);
    check("wr s_addr", s_addr, 32'h0);
    check("wr s_wdata", s_wdata, 32'h1234_5678);
    check("wr s_wstrb", s_wstrb, 4'b1010);
    check("wr m0_ready early", m0_ready, 1'b0);
    s_ready = 1'b1; s_rdata = 32'h5555_0000;
    #1;
    check("wr m0_ready", m0_ready, 1'b1);
    check("wr m1_ready", m1_ready, 1'b0);
    tick();
    s_ready = 1'b0; m0_valid = 1'b0;
    check("wr release s_valid", s_valid, 1'b0);
    tick();
    check("wr idle s_valid", s_valid, 1'b0);

    // Contention: reset so port 0 wins first, then four requests per port.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h100; m0_wdata = 32'hA0A0_0000; m0_wstrb = 4'hF;
    m1_valid = 1'b1; m1_addr = 32'h200; m1_wdata = 32'hB0B0_0000; m1_wstrb = 4'h3;
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 8; k++) begin
      wait_svalid(4, "rr grant timely");
      s_ready = 1'b1; s_rdata = 32'(k);
      #1;
      g = m1_ready;
      check($sformatf("rr grant %0d", k), g, k % 2);
      check("rr one-hot ready", m0_ready ^ m1_ready, 1'b1);
      tick();
      s_ready = 1'b0;
      if (g) begin
        cnt1++; m1_addr = m1_addr + 1;
        if (cnt1 == 4) m1_valid = 1'b0;
      end else begin
        cnt0++; m0_addr = m0_addr + 1;
        if (cnt0 == 4) m0_valid = 1'b0;
      end
    end

    // Read routed to port 1 while port 0 raises a request on the ready cycle.
    m1_valid = 1'b1; m1_addr = 32'h2; m1_wstrb = 4'h0;
    wait_svalid(4, "rd grant timely");
    check("rd s_addr", s_addr, 32'h2);
    check("rd s_wstrb", s_wstrb, 4'h0);
    s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
    m0_valid = 1'b1; m0_addr = 32'h40; m0_wstrb = 4'h1;
    #1;
    check("rd m1_rdata", m1_rdata, 32'hCAFE_F00D);
    check("rd m1_ready", m1_ready, 1'b1);
    check("rd m0_rdata", m0_rdata, 32'h0);
    check("rd m0_ready", m0_ready, 1'b0);
    tick();
    s_ready = 1'b0; m1_valid = 1'b0;
    check("turn release s_valid", s_valid, 1'b0);
    tick();
    check("turn idle s_valid", s_valid, 1'b0);
    tick();
    check("turn grant s_valid", s_valid, 1'b1);
    check("turn grant s_addr", s_addr, 32'h40);

    // Reset in the middle of a port-0 transaction.
    rst = 1'b1; s_ready = 1'b1;
    #1;
    check("rstbusy s_valid", s_valid, 1'b0);
    check("rstbusy m0_ready", m0_ready, 1'b0);
    tick();
    rst = 1'b0; s_ready = 1'b0; m0_valid = 1'b0;
    check("rstbusy after s_valid", s_valid, 1'b0);
    tick();
    check("rstbusy idle s_valid", s_valid, 1'b0);
    m0_valid = 1'b1;
    tick();
    check("rstbusy regrant s_valid", s_valid, 1'b1);
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0; m0_valid = 1'b0;
    tick();

`ifdef HRAM_ARB_TIMEOUT_EN
    // Watchdog: downstream never answers.
    m0_valid = 1'b1; m0_addr = 32'h8; m0_wstrb = 4'h0;
    tick();
    n = 1;
    while (!m0_ready && n < 40) begin
      tick();
      n++;
    end
    check("to busy cycles", 32'(n), 32'(TO_CYC));
    check("to m0_ready", m0_ready, 1'b1);
    check("to m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    tick();
    m0_valid = 1'b0;
    check("to flag set", timeout, 1'b1);
    tick();
    tick();
    check("to flag sticky", timeout, 1'b1);
`else
    n = 0;
    check("to tied low", timeout, 1'b0);
`endif

    tick();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
